// File: rtl/rr_mux_pkg.sv
// Shared definitions for the rr_mux_n channel multiplexer: mode encodings,
// lock FSM states and the rotate-and-find-first scan used by the arbiter.
package rr_mux_pkg;

   localparam logic MODE_SEL = 1'b0;
   localparam logic MODE_RR  = 1'b1;

   // Upper bound on CHANNELS; the scan helper works on a fixed-width vector.
   localparam int MAX_CH = 32;
   localparam int IDX_W  = 5;

   typedef enum logic {
      LK_IDLE   = 1'b0,
      LK_LOCKED = 1'b1
   } lock_state_t;

   typedef struct packed {
      logic             found;
      logic [IDX_W-1:0] idx;
   } rr_pick_t;

   // First set bit of req at or above ptr, wrapping modulo n. The loop runs
   // downward so the lowest rotated offset is the last one written.
   function automatic rr_pick_t rr_find_first(input logic [MAX_CH-1:0] req,
                                              input logic [IDX_W-1:0]  ptr,
                                              input int                n);
      rr_pick_t p;
      int       c;
      p = '0;
      for (int i = MAX_CH - 1; i >= 0; i--) begin
         if (i < n) begin
            c = int'(ptr) + i;
            if (c >= n) c = c - n;
            if (req[c[IDX_W-1:0]]) begin
               p.found = 1'b1;
               p.idx   = c[IDX_W-1:0];
            end
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/rr_mux_if.sv
// Handshake and data bundle for rr_mux_n. master = producers/consumer side,
// slave = the multiplexer. in_last_i exists only when RR_MUX_LOCK_EN is defined.
interface rr_mux_if #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 8
);
   localparam int SEL_W = $clog2(CHANNELS);

   logic                      mode_i;
   logic [SEL_W-1:0]          sel_i;
   logic [CHANNELS-1:0]       in_valid_i;
   logic [CHANNELS*WIDTH-1:0] in_data_i;
`ifdef RR_MUX_LOCK_EN
   logic [CHANNELS-1:0]       in_last_i;
`endif
   logic [CHANNELS-1:0]       in_ready_o;
   logic                      out_valid_o;
   logic [WIDTH-1:0]          out_data_o;
   logic [SEL_W-1:0]          out_chan_o;
   logic                      out_ready_i;

   modport master (
`ifdef RR_MUX_LOCK_EN
      output in_last_i,
`endif
      output mode_i, sel_i, in_valid_i, in_data_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_data_o, out_chan_o
   );

   modport slave (
`ifdef RR_MUX_LOCK_EN
      input  in_last_i,
`endif
      input  mode_i, sel_i, in_valid_i, in_data_i, out_ready_i,
      output in_ready_o, out_valid_o, out_data_o, out_chan_o
   );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin priority scan over CHANNELS request bits plus the rotating
// start pointer. The pointer moves only when the parent says a transfer
// should advance it.
module rr_arbiter
   import rr_mux_pkg::*;
#(
   parameter int CHANNELS = 8,
   parameter int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] req,
   input  logic                advance,
   input  logic [SEL_W-1:0]    adv_ch,
   output logic [SEL_W-1:0]    gnt_idx,
   output logic                gnt_vld
);

   logic [SEL_W-1:0]  ptr_q;
   logic [MAX_CH-1:0] req_ext;
   rr_pick_t          pick;

   // Rotated first-one search starting at ptr_q.
   always_comb begin
      req_ext                 = '0;
      req_ext[CHANNELS-1:0]   = req;
      pick                    = rr_find_first(req_ext, IDX_W'(ptr_q), CHANNELS);
   end

   assign gnt_idx = SEL_W'(pick.idx);
   assign gnt_vld = pick.found;

   // Pointer moves past the served channel; explicit wrap for non-power-of-2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (advance) begin
         ptr_q <= (adv_ch == SEL_W'(CHANNELS - 1)) ? '0 : adv_ch + SEL_W'(1);
      end
   end

endmodule

// File: rtl/rr_mux_n.sv
// Registered N-channel multiplexer with valid/ready handshakes, selecting by
// explicit index or round-robin. Optional packet lock under RR_MUX_LOCK_EN.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   LK_IDLE   | every beat arbitrated independently (mode_i/sel_i/ptr)
//   LK_LOCKED | mid-packet; only lock_ch may transfer until its last beat
module rr_mux_n #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 8
) (
   input logic      clk,
   input logic      rst_n,
   rr_mux_if.slave  bus
);
   import rr_mux_pkg::*;

   localparam int SEL_W = $clog2(CHANNELS);

   logic                free;
   logic                sel_ok;
   logic                cand_vld;
   logic                xfer;
   logic                advance;
   logic                locked;
   logic [SEL_W-1:0]    lock_ch;
   logic [SEL_W-1:0]    gnt;
   logic [SEL_W-1:0]    arb_idx;
   logic                arb_vld;
   logic [MAX_CH-1:0]   valid_ext;
   logic [WIDTH-1:0]    gnt_data;
   logic [CHANNELS-1:0] ready;
   logic                out_valid;
   logic [WIDTH-1:0]    out_data;
   logic [SEL_W-1:0]    out_chan;

   // Zero-extended valids so out-of-range selects read as not valid.
   always_comb begin
      valid_ext                 = '0;
      valid_ext[CHANNELS-1:0]   = bus.in_valid_i;
   end

`ifdef RR_MUX_LOCK_EN
   lock_state_t       state_q, state_d;
   logic [SEL_W-1:0]  lock_ch_q, lock_ch_d;
   logic [MAX_CH-1:0] last_ext;
   logic              last_g;

   // Last-beat flag of whichever channel is granted this cycle.
   always_comb begin
      last_ext                 = '0;
      last_ext[CHANNELS-1:0]   = bus.in_last_i;
      last_g                   = last_ext[IDX_W'(gnt)];
   end

   // Lock FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= LK_IDLE;
         lock_ch_q <= '0;
      end else begin
         state_q   <= state_d;
         lock_ch_q <= lock_ch_d;
      end
   end

   // Lock FSM next state: open on a non-last beat, close on the last one.
   always_comb begin
      state_d   = state_q;
      lock_ch_d = lock_ch_q;
      case (state_q)
         LK_IDLE: begin
            if (xfer && !last_g) begin
               state_d   = LK_LOCKED;
               lock_ch_d = gnt;
            end
         end
         LK_LOCKED: begin
            if (xfer && last_g) state_d = LK_IDLE;
         end
         default: state_d = LK_IDLE;
      endcase
   end

   assign locked  = (state_q == LK_LOCKED);
   assign lock_ch = lock_ch_q;
   // Pointer moves only when a packet (or single beat) completes.
   assign advance = xfer && last_g && (locked || bus.mode_i == MODE_RR);
`else
   assign locked  = 1'b0;
   assign lock_ch = '0;
   assign advance = xfer && (bus.mode_i == MODE_RR);
`endif

   rr_arbiter #(
      .CHANNELS (CHANNELS),
      .SEL_W    (SEL_W)
   ) u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (bus.in_valid_i),
      .advance  (advance),
      .adv_ch   (gnt),
      .gnt_idx  (arb_idx),
      .gnt_vld  (arb_vld)
   );

   // Grant selection: lock overrides mode, select mode overrides round-robin.
   always_comb begin
      sel_ok   = int'(bus.sel_i) < CHANNELS;
      gnt      = arb_idx;
      cand_vld = arb_vld;
      if (locked) begin
         gnt      = lock_ch;
         cand_vld = valid_ext[IDX_W'(lock_ch)];
      end else if (bus.mode_i == MODE_SEL) begin
         gnt      = bus.sel_i;
         cand_vld = sel_ok && valid_ext[IDX_W'(bus.sel_i)];
      end
   end

   assign free = !out_valid || bus.out_ready_i;
   // rst_n gating keeps in_ready_o low for the whole reset assertion.
   assign xfer = rst_n && free && cand_vld;

   // One-hot ready and data mux for the granted channel.
   always_comb begin
      ready    = '0;
      gnt_data = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (gnt == SEL_W'(k)) begin
            ready[k] = xfer;
            gnt_data = bus.in_data_i[k*WIDTH +: WIDTH];
         end
      end
   end

   // One-deep output stage: load on transfer, drain when consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= gnt_data;
         out_chan  <= gnt;
      end else if (bus.out_ready_i) begin
         out_valid <= 1'b0;
      end
   end

   assign bus.in_ready_o  = ready;
   assign bus.out_valid_o = out_valid;
   assign bus.out_data_o  = out_data;
   assign bus.out_chan_o  = out_chan;

endmodule

// File: tb/tb_rr_mux_n.sv
// Directed bench for rr_mux_n: an 8-channel and a 5-channel instance on a
// shared clock/reset. Lock-mode vectors build only with RR_MUX_LOCK_EN.
module tb_rr_mux_n;

   logic clk = 1'b0;
   logic rst_n;
   int   n_vec  = 0;
   int   n_miss = 0;

   always #5 clk = ~clk;

   rr_mux_if #(.WIDTH(32), .CHANNELS(8)) if8 ();
   rr_mux_if #(.WIDTH(32), .CHANNELS(5)) if5 ();

   rr_mux_n #(.WIDTH(32), .CHANNELS(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8));
   rr_mux_n #(.WIDTH(32), .CHANNELS(5)) u5 (.clk(clk), .rst_n(rst_n), .bus(if5));

   task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out8(input string tag, input int ch);
      chk_val({tag, " valid"}, 64'(if8.out_valid_o), 64'd1);
      chk_val({tag, " chan"},  64'(if8.out_chan_o),  64'(ch));
      chk_val({tag, " data"},  64'(if8.out_data_o),  64'(32'hA000_0000 | ch));
   endtask

   initial begin
      rst_n           = 1'b0;
      if8.mode_i      = 1'b1;
      if8.sel_i       = '0;
      if8.in_valid_i  = 8'hFF;
      if8.out_ready_i = 1'b1;
      if5.mode_i      = 1'b0;
      if5.sel_i       = '0;
      if5.in_valid_i  = '0;
      if5.out_ready_i = 1'b1;
`ifdef RR_MUX_LOCK_EN
      if8.in_last_i   = 8'hFF;
      if5.in_last_i   = 5'h1F;
`endif
      for (int k = 0; k < 8; k++) if8.in_data_i[k*32 +: 32] = 32'hA000_0000 | k;
      for (int k = 0; k < 5; k++) if5.in_data_i[k*32 +: 32] = 32'hA000_0000 | k;

      // reset values, with all channels requesting
      #12;
      chk_val("rst valid", 64'(if8.out_valid_o), 64'd0);
      chk_val("rst data",  64'(if8.out_data_o),  64'd0);
      chk_val("rst chan",  64'(if8.out_chan_o),  64'd0);
      chk_val("rst ready", 64'(if8.in_ready_o),  64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      // round-robin fairness: 0..7 then wrap to 0, no bubbles
      chk_val("rr ready0", 64'(if8.in_ready_o), 64'h01);
      for (int i = 0; i < 9; i++) begin
         tick();
         chk_out8("rr", i % 8);
      end

      // backpressure while channel 2 is held
      tick();
      tick();
      chk_out8("bp pre", 2);
      if8.out_ready_i = 1'b0;
      #1;
      chk_val("bp ready", 64'(if8.in_ready_o), 64'h00);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out8("bp hold", 2);
         chk_val("bp hold ready", 64'(if8.in_ready_o), 64'h00);
      end
      if8.out_ready_i = 1'b1;
      #1;
      chk_val("bp resume ready", 64'(if8.in_ready_o), 64'h08);
      tick();
      chk_out8("bp resume", 3);

      // select mode: only channel 5 even though channel 2 also valid
      if8.mode_i     = 1'b0;
      if8.sel_i      = 3'd5;
      if8.in_valid_i = 8'b0010_0100;
      #1;
      chk_val("sel ready", 64'(if8.in_ready_o), 64'h20);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out8("sel", 5);
         chk_val("sel ready hold", 64'(if8.in_ready_o), 64'h20);
      end
      // select an idle channel: nothing granted, output drains but holds data
      if8.sel_i = 3'd3;
      #1;
      chk_val("sel idle ready", 64'(if8.in_ready_o), 64'h00);
      tick();
      chk_val("drain valid", 64'(if8.out_valid_o), 64'd0);
      chk_val("drain chan",  64'(if8.out_chan_o),  64'd5);
      chk_val("drain data",  64'(if8.out_data_o),  64'hA000_0005);
      // select transfers left ptr at 4 (after channel 3)
      if8.mode_i     = 1'b1;
      if8.in_valid_i = 8'hFF;
      #1;
      chk_val("ptr kept ready", 64'(if8.in_ready_o), 64'h10);
      tick();
      chk_out8("ptr kept", 4);

      // asynchronous reset while holding a word
      rst_n = 1'b0;
      #1;
      chk_val("mid rst valid", 64'(if8.out_valid_o), 64'd0);
      chk_val("mid rst data",  64'(if8.out_data_o),  64'd0);
      chk_val("mid rst chan",  64'(if8.out_chan_o),  64'd0);
      chk_val("mid rst ready", 64'(if8.in_ready_o),  64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk_out8("post rst", 0);

      // five channels: out-of-range select, then round-robin wrap 4->0
      if8.in_valid_i = '0;
      if5.mode_i     = 1'b0;
      if5.sel_i      = 3'd6;
      if5.in_valid_i = 5'h1F;
      #1;
      chk_val("n5 sel6 ready", 64'(if5.in_ready_o), 64'd0);
      tick();
      chk_val("n5 sel6 valid", 64'(if5.out_valid_o), 64'd0);
      if5.mode_i = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         chk_val("n5 rr valid", 64'(if5.out_valid_o), 64'd1);
         chk_val("n5 rr chan",  64'(if5.out_chan_o),  64'(i % 5));
         chk_val("n5 rr data",  64'(if5.out_data_o),  64'(32'hA000_0000 | (i % 5)));
      end
      if5.in_valid_i = '0;

`ifdef RR_MUX_LOCK_EN
      // channel 3 sends a 3-beat packet; channel 4 waits; mode change ignored
      rst_n = 1'b0;
      #1;
      @(negedge clk);
      rst_n          = 1'b1;
      if8.mode_i     = 1'b1;
      if8.in_valid_i = 8'h18;
      if8.in_last_i  = 8'hF7;
      tick();
      chk_out8("lock b1", 3);
      if8.mode_i = 1'b0;
      if8.sel_i  = 3'd4;
      #1;
      chk_val("lock ready", 64'(if8.in_ready_o), 64'h08);
      tick();
      chk_out8("lock b2", 3);
      if8.in_last_i = 8'hFF;
      tick();
      chk_out8("lock b3", 3);
      if8.in_valid_i = 8'h10;
      tick();
      chk_out8("lock next", 4);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
